// File: rtl/conv_seq_pkg.sv
// Shared sizes, FSM state type and output-address helper for the conv layer sequencer.
package conv_seq_pkg;
  localparam int DATA_WIDTH      = 16;
  localparam int OUTPUT_CHANNELS = 4;
  localparam int OUTPUT_COL_SIZE = 24;
  localparam int MAX_PASSES      = 8;
  localparam int ADDR_WIDTH      = 12;
  localparam int WORD_WIDTH      = 256;

  localparam int LANES_PER_WORD = WORD_WIDTH / DATA_WIDTH;
  localparam int WORDS_PER_COL  = (OUTPUT_COL_SIZE + LANES_PER_WORD - 1) / LANES_PER_WORD;

  localparam int NP_W   = $clog2(MAX_PASSES + 1);
  localparam int PASS_W = $clog2(MAX_PASSES);
  localparam int CH_W   = $clog2(OUTPUT_CHANNELS);
  localparam int COL_W  = $clog2(OUTPUT_COL_SIZE + 1);
  localparam int WORD_W = (WORDS_PER_COL > 1) ? $clog2(WORDS_PER_COL) : 1;

  typedef enum logic [2:0] {IDLE, START, RUN, NEXT, FINISH} state_t;

  // Channel-major layout: each (pass, channel) owns OUTPUT_COL_SIZE columns of WORDS_PER_COL words.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [PASS_W-1:0]     pass,
    input logic [CH_W-1:0]       ch,
    input logic [COL_W-1:0]      col,
    input logic [WORD_W-1:0]     w
  );
    logic [31:0] offset;
    offset = ((32'(pass) * OUTPUT_CHANNELS + 32'(ch)) * OUTPUT_COL_SIZE + 32'(col))
             * WORDS_PER_COL + 32'(w);
    return base + offset[ADDR_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/conv_col_packer.sv
// Captures one engine output column and streams it to the output BRAM as 256-bit words.
module conv_col_packer
  import conv_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  capture_en,
  input  logic                  conv_valid,
  input  logic [OUTPUT_CHANNELS-1:0][OUTPUT_COL_SIZE-1:0][DATA_WIDTH-1:0] conv_col,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [PASS_W-1:0]     pass,
  input  logic [COL_W-1:0]      col,
  input  logic                  wr_ready,
  output logic                  buf_free,
  output logic                  capture,
  output logic                  writer_idle,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [WORD_WIDTH-1:0] wr_data
);
  logic [OUTPUT_CHANNELS-1:0][OUTPUT_COL_SIZE-1:0][DATA_WIDTH-1:0] col_buf_reg;
  logic                  active_reg;
  logic [CH_W-1:0]       ch_reg;
  logic [WORD_W-1:0]     w_reg;
  logic [PASS_W-1:0]     pass_reg;
  logic [COL_W-1:0]      col_reg;
  logic                  accept;
  logic                  last_word;
  logic                  last_w;
  logic [DATA_WIDTH-1:0] lane_val [WORDS_PER_COL][LANES_PER_WORD];

  assign accept      = active_reg && wr_ready;
  assign last_w      = (w_reg == WORD_W'(WORDS_PER_COL - 1));
  assign last_word   = last_w && (ch_reg == CH_W'(OUTPUT_CHANNELS - 1));
  // Freeing on the final accept lets a back-to-back column land without a gap.
  assign buf_free    = !active_reg || (accept && last_word);
  assign capture     = capture_en && conv_valid && buf_free;
  assign writer_idle = !active_reg;
  assign wr_en       = active_reg;
  assign wr_addr     = word_addr(base, pass_reg, ch_reg, col_reg, w_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_buf_reg <= '0;
      active_reg  <= 1'b0;
      ch_reg      <= '0;
      w_reg       <= '0;
      pass_reg    <= '0;
      col_reg     <= '0;
    end else begin
      if (accept) begin
        if (last_w) begin
          w_reg  <= '0;
          ch_reg <= ch_reg + 1'b1;
        end else begin
          w_reg <= w_reg + 1'b1;
        end
        if (last_word) active_reg <= 1'b0;
      end
      if (capture) begin
        col_buf_reg <= conv_col;
        active_reg  <= 1'b1;
        ch_reg      <= '0;
        w_reg       <= '0;
        pass_reg    <= pass;
        col_reg     <= col;
      end
    end
  end

  for (genvar gw = 0; gw < WORDS_PER_COL; gw++) begin : g_word
    for (genvar gi = 0; gi < LANES_PER_WORD; gi++) begin : g_lane
      if (gw * LANES_PER_WORD + gi < OUTPUT_COL_SIZE) begin : g_elem
        assign lane_val[gw][gi] = col_buf_reg[ch_reg][gw * LANES_PER_WORD + gi];
      end else begin : g_pad
        assign lane_val[gw][gi] = '0;
      end
    end
  end

  always_comb begin
    wr_data = '0;
    for (int l = 0; l < LANES_PER_WORD; l++) begin
      wr_data[l*DATA_WIDTH +: DATA_WIDTH] = lane_val[w_reg][l];
    end
  end
endmodule

// File: rtl/conv_layer_sequencer.sv
// Runs the conv engine through N kernel passes and hands each output column to the packer.
module conv_layer_sequencer
  import conv_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_start,
  input  logic [NP_W-1:0]       cmd_num_passes,
  input  logic [ADDR_WIDTH-1:0] cmd_out_base,
  output logic                  busy,
  output logic                  done,
  output logic                  err_overrun,
  output logic                  err_short,
  output logic [PASS_W-1:0]     pass_idx,
  output logic                  conv_start,
  input  logic                  conv_valid,
  input  logic                  conv_done,
  input  logic [OUTPUT_CHANNELS-1:0][OUTPUT_COL_SIZE-1:0][DATA_WIDTH-1:0] conv_col,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  wr_ready
);
  state_t                state_reg, state_next;
  logic [NP_W-1:0]       num_passes_reg, num_passes_next;
  logic [ADDR_WIDTH-1:0] base_reg, base_next;
  logic [PASS_W-1:0]     pass_idx_reg, pass_idx_next;
  logic [COL_W-1:0]      col_cnt_reg, col_cnt_next;
  logic                  done_seen_reg, done_seen_next;
  logic                  err_overrun_reg, err_overrun_next;
  logic                  err_short_reg, err_short_next;
  logic [NP_W-1:0]       passes_clamped;
  logic                  buf_free, capture, writer_idle;

  assign passes_clamped = (cmd_num_passes > NP_W'(MAX_PASSES)) ? NP_W'(MAX_PASSES) : cmd_num_passes;
  assign pass_idx    = pass_idx_reg;
  assign err_overrun = err_overrun_reg;
  assign err_short   = err_short_reg;

  conv_col_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .capture_en  (state_reg == RUN),
    .conv_valid  (conv_valid),
    .conv_col    (conv_col),
    .base        (base_reg),
    .pass        (pass_idx_reg),
    .col         (col_cnt_reg),
    .wr_ready    (wr_ready),
    .buf_free    (buf_free),
    .capture     (capture),
    .writer_idle (writer_idle),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      num_passes_reg  <= '0;
      base_reg        <= '0;
      pass_idx_reg    <= '0;
      col_cnt_reg     <= '0;
      done_seen_reg   <= 1'b0;
      err_overrun_reg <= 1'b0;
      err_short_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      num_passes_reg  <= num_passes_next;
      base_reg        <= base_next;
      pass_idx_reg    <= pass_idx_next;
      col_cnt_reg     <= col_cnt_next;
      done_seen_reg   <= done_seen_next;
      err_overrun_reg <= err_overrun_next;
      err_short_reg   <= err_short_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    num_passes_next  = num_passes_reg;
    base_next        = base_reg;
    pass_idx_next    = pass_idx_reg;
    col_cnt_next     = col_cnt_reg;
    done_seen_next   = done_seen_reg;
    err_overrun_next = err_overrun_reg;
    err_short_next   = err_short_reg;
    busy             = 1'b0;
    done             = 1'b0;
    conv_start       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_start) begin
          num_passes_next  = passes_clamped;
          base_next        = cmd_out_base;
          pass_idx_next    = '0;
          err_overrun_next = 1'b0;
          err_short_next   = 1'b0;
          state_next       = (passes_clamped == '0) ? FINISH : START;
        end
      end
      START: begin
        busy           = 1'b1;
        conv_start     = 1'b1;
        col_cnt_next   = '0;
        done_seen_next = 1'b0;
        state_next     = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (capture) col_cnt_next = col_cnt_reg + 1'b1;
        if (conv_valid && !buf_free) err_overrun_next = 1'b1;
        if (conv_done) done_seen_next = 1'b1;
        // A column captured this cycle still has to drain before the pass can close.
        if (done_seen_reg && writer_idle && !capture) begin
          if (col_cnt_reg != COL_W'(OUTPUT_COL_SIZE)) err_short_next = 1'b1;
          state_next = NEXT;
        end
      end
      NEXT: begin
        busy          = 1'b1;
        pass_idx_next = pass_idx_reg + 1'b1;
        state_next    = (NP_W'(pass_idx_reg) + NP_W'(1) == num_passes_reg) ? FINISH : START;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench: engine model drives columns, expected BRAM words go through a queue scoreboard.
module tb_conv_layer_sequencer;
  localparam int DW = 16, CH = 4, COLS = 24, AW = 12, WW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_start;
  logic [3:0]    cmd_num_passes;
  logic [AW-1:0] cmd_out_base;
  logic          busy, done, err_overrun, err_short;
  logic [2:0]    pass_idx;
  logic          conv_start, conv_valid, conv_done;
  logic [CH-1:0][COLS-1:0][DW-1:0] conv_col;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [WW-1:0] wr_data;
  logic          wr_ready;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
  } wr_t;

  wr_t           sb[$];
  int            total = 0, bad = 0, cyc = 0;
  int            wr_cnt = 0, done_cnt = 0, start_cnt = 0, wr_en_cnt = 0;
  logic          rand_ready = 1'b0;
  logic          pend_v = 1'b0;
  logic [AW-1:0] pend_addr;
  logic [WW-1:0] pend_data;
  logic [WW-1:0] rec_16b = '0;

  conv_layer_sequencer dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_num_passes(cmd_num_passes),
    .cmd_out_base(cmd_out_base), .busy(busy), .done(done), .err_overrun(err_overrun),
    .err_short(err_short), .pass_idx(pass_idx), .conv_start(conv_start),
    .conv_valid(conv_valid), .conv_done(conv_done), .conv_col(conv_col),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] elem(input int p, input int ch, input int i, input int k, input int salt);
    return {3'(p), 2'(ch), 5'(i), 5'(k), 1'(salt)};
  endfunction

  function automatic logic [WW-1:0] exp_word(input int p, input int ch, input int i, input int w, input int salt);
    logic [WW-1:0] r;
    r = '0;
    for (int l = 0; l < 16; l++)
      if (16 * w + l < COLS) r[l*DW +: DW] = elem(p, ch, i, 16 * w + l, salt);
    return r;
  endfunction

  // Monitor: every accepted word is popped and compared; held words must stay frozen.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_v = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (conv_start) start_cnt++;
        if (wr_en) wr_en_cnt++;
        if (pend_v) begin
          check("hold_en", wr_en, 1'b1);
          check("hold_addr", wr_addr, pend_addr);
          check("hold_data", wr_data, pend_data);
        end
        pend_v = wr_en && !wr_ready;
        pend_addr = wr_addr;
        pend_data = wr_data;
        if (wr_en && wr_ready) begin
          wr_cnt++;
          if (wr_addr == 12'h16B) rec_16b = wr_data;
          check("write_expected", sb.size() != 0, 1'b1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("wr_addr", wr_addr, e.addr);
            check("wr_data", wr_data, e.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) wr_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic start_cmd(input int np, input logic [AW-1:0] base);
    cmd_num_passes = 4'(np);
    cmd_out_base   = base;
    cmd_start      = 1'b1;
    tick();
    cmd_start      = 1'b0;
  endtask

  task automatic emit_col(input int p, input int i, input int salt, input logic cap,
                          input int col, input logic [AW-1:0] base);
    wr_t e;
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < COLS; k++) conv_col[c][k] = elem(p, c, i, k, salt);
    conv_valid = 1'b1;
    if (cap) begin
      for (int c = 0; c < CH; c++)
        for (int w = 0; w < 2; w++) begin
          e.addr = base + AW'(((p * CH + c) * COLS + col) * 2 + w);
          e.data = exp_word(p, c, i, w, salt);
          sb.push_back(e);
        end
    end
    tick();
    conv_valid = 1'b0;
  endtask

  // Capture model: with wr_ready held high a column occupies the writer for 8 cycles.
  task automatic run_pass(input int p, input int ncols, input int gap, input logic [AW-1:0] base,
                          input int salt, input logic inject);
    int   n, free_cyc, captured, cd;
    logic cap;
    n = 0; free_cyc = 0; captured = 0;
    while (!conv_start && n < 40) begin tick(); n++; end
    check("conv_start_seen", conv_start, 1'b1);
    check("pass_idx", pass_idx, 3'(p));
    for (int i = 0; i < ncols; i++) begin
      repeat (gap - 1) tick();
      cd  = cyc;
      cap = rand_ready || (cd >= free_cyc);
      if (inject && i == 3) begin
        cmd_start = 1'b1; cmd_num_passes = 4'd1; cmd_out_base = 12'hABC;
      end
      emit_col(p, i, salt, cap, captured, base);
      cmd_start = 1'b0;
      if (cap) begin captured++; free_cyc = cd + 8; end
    end
    repeat (12) tick();
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string tag);
    int n;
    n = 0;
    while (!done && n < limit) begin tick(); n++; end
    check(tag, done, 1'b1);
  endtask

  initial begin
    int d0, s0, w0, e0;
    rst = 1'b1; cmd_start = 1'b0; cmd_num_passes = '0; cmd_out_base = '0;
    conv_valid = 1'b0; conv_done = 1'b0; conv_col = '0; wr_ready = 1'b1;
    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err_overrun", err_overrun, 1'b0);
    check("rst_err_short", err_short, 1'b0);
    check("rst_pass_idx", pass_idx, 3'd0);
    check("rst_conv_start", conv_start, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_wr_addr", wr_addr, 12'd0);
    check("rst_wr_data", wr_data, '0);
    rst = 1'b0;
    tick();

    // Single pass at 0x100
    d0 = done_cnt; w0 = wr_cnt;
    start_cmd(1, 12'h100);
    check("A_busy", busy, 1'b1);
    check("A_conv_start_next_cycle", conv_start, 1'b1);
    run_pass(0, 24, 20, 12'h100, 0, 1'b0);
    wait_done(60, "A_done");
    check("A_sb_empty_at_done", sb.size(), 0);
    check("A_err_overrun", err_overrun, 1'b0);
    check("A_err_short", err_short, 1'b0);
    tick();
    check("A_busy_after", busy, 1'b0);
    check("A_done_count", done_cnt - d0, 1);
    check("A_write_count", wr_cnt - w0, 192);
    check("A_word_16b", rec_16b, exp_word(0, 2, 5, 1, 0));
    check("A_word_16b_upper_zero", rec_16b[WW-1:128], 128'd0);

    // Three passes at base 0, with an ignored cmd_start mid-run
    d0 = done_cnt; s0 = start_cnt; w0 = wr_cnt;
    start_cmd(3, 12'h000);
    for (int p = 0; p < 3; p++) run_pass(p, 24, 20, 12'h000, 1, p == 0);
    wait_done(60, "B_done");
    check("B_sb_empty_at_done", sb.size(), 0);
    check("B_err_overrun", err_overrun, 1'b0);
    check("B_err_short", err_short, 1'b0);
    tick();
    check("B_write_count", wr_cnt - w0, 576);
    check("B_conv_start_count", start_cnt - s0, 3);
    check("B_done_count", done_cnt - d0, 1);

    // Random back-pressure
    rand_ready = 1'b1;
    start_cmd(1, 12'h200);
    run_pass(0, 24, 40, 12'h200, 1, 1'b0);
    wait_done(400, "C_done");
    rand_ready = 1'b0; wr_ready = 1'b1;
    check("C_sb_empty", sb.size(), 0);
    check("C_err_overrun", err_overrun, 1'b0);
    tick();

    // Overrun and short pass
    d0 = done_cnt;
    start_cmd(1, 12'h300);
    run_pass(0, 24, 4, 12'h300, 0, 1'b0);
    wait_done(60, "D_done");
    check("D_err_overrun", err_overrun, 1'b1);
    check("D_err_short", err_short, 1'b1);
    check("D_sb_empty", sb.size(), 0);
    tick();
    check("D_done_count", done_cnt - d0, 1);

    // Zero passes: immediate done, no engine start, no writes; flags cleared
    d0 = done_cnt; s0 = start_cnt; e0 = wr_en_cnt;
    start_cmd(0, 12'h007);
    check("E_err_overrun_cleared", err_overrun, 1'b0);
    check("E_err_short_cleared", err_short, 1'b0);
    wait_done(1, "E_done");
    tick();
    tick();
    check("E_conv_start_count", start_cnt - s0, 0);
    check("E_wr_en_count", wr_en_cnt - e0, 0);
    check("E_done_count", done_cnt - d0, 1);
    check("E_busy", busy, 1'b0);

    // Reset with the 3rd word of a column pending
    start_cmd(1, 12'h040);
    tick();
    emit_col(0, 0, 1, 1'b1, 0, 12'h040);
    check("F_wr_en_up", wr_en, 1'b1);
    tick();
    tick();
    wr_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("F_rst_wr_en", wr_en, 1'b0);
    check("F_rst_wr_addr", wr_addr, 12'd0);
    check("F_rst_wr_data", wr_data, '0);
    check("F_rst_busy", busy, 1'b0);
    check("F_rst_pass_idx", pass_idx, 3'd0);
    check("F_sb_remaining", sb.size(), 6);
    sb.delete();
    repeat (3) tick();
    rst = 1'b0;
    wr_ready = 1'b1;
    e0 = wr_en_cnt;
    repeat (10) tick();
    check("F_no_wr_after_rst", wr_en_cnt - e0, 0);
    start_cmd(1, 12'h040);
    run_pass(0, 24, 20, 12'h040, 0, 1'b0);
    wait_done(60, "F_done");
    check("F_sb_empty", sb.size(), 0);
    check("F_err_overrun", err_overrun, 1'b0);
    check("F_err_short", err_short, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
